// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and default bit timing for the serial receiver
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } serial_state_e;

    localparam int CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/baud_tick_counter.sv
// rtl/baud_tick_counter.sv - up-counter with sync clear/enable; ticks when count equals term_i
module baud_tick_counter #(
    parameter int CNT_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == term_i);

    // Holds at the terminal count; only an explicit clear restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tick_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// rtl/serial_byte_receiver.sv - 8N1 serial deserializer; SERIAL_RX_PARITY_EN selects 8E1 with ParityError
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Rx,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  Valid,
    output logic                  FramingError,
`ifdef SERIAL_RX_PARITY_EN
    output logic                  ParityError,
`endif
    output logic                  Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

    serial_state_e         state_q, state_d;
    logic                  rx_meta_q, rxs_q;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  fe_q, fe_d;
    logic                  pe_q, pe_d;
    logic                  par_q, par_d;
    logic                  cnt_clr, cnt_en, tick;
    logic [CNT_W-1:0]      cnt_term;

    baud_tick_counter #(.CNT_W(CNT_W)) u_baud (
        .clk_i  (Clock),
        .rst_i  (Reset),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .term_i (cnt_term),
        .tick_o (tick)
    );

    assign cnt_en = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        fe_d     = 1'b0;
        pe_d     = 1'b0;
        par_d    = par_q;
        cnt_clr  = 1'b0;
        cnt_term = FULL_TERM;
        case (state_q)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs_q) state_d = ST_START;
            end
            ST_START: begin
                cnt_term = HALF_TERM;
                if (tick) begin
                    if (rxs_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_clr = 1'b1;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_clr        = 1'b1;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    cnt_clr = 1'b1;
                    par_d   = rxs_q;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                    if (!rxs_q) begin
                        fe_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    end else if (^{shift_q, par_q}) begin
                        pe_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            rx_meta_q <= Rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            par_q     <= par_d;
        end
    end

    assign Data         = data_q;
    assign Valid        = valid_q;
    assign FramingError = fe_q;
    assign Busy         = (state_q != ST_IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign ParityError  = pe_q;
`endif

endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb/tb_serial_byte_receiver.sv - directed and randomized frames against a frame-level reference model
module tb_serial_byte_receiver;

    localparam int CPB = 16;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Rx;
    logic [7:0] Data;
    logic       Valid;
    logic       FramingError;
    logic       Busy;
`ifdef SERIAL_RX_PARITY_EN
    logic       ParityError;
`endif

    serial_byte_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Rx           (Rx),
        .Data         (Data),
        .Valid        (Valid),
        .FramingError (FramingError),
`ifdef SERIAL_RX_PARITY_EN
        .ParityError  (ParityError),
`endif
        .Busy         (Busy)
    );

    always #5 Clock = ~Clock;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_data = 8'h00;
    int         exp_fe = 0;
    int         exp_pe = 0;
    int         fe_cnt = 0;
    int         pe_cnt = 0;
    int         excl_bad = 0;
    logic       busy_after = 1'b1;
    logic       prev_valid = 1'b0;
    time        t_fall = 0;
    time        t_valid = 0;

    always @(negedge Clock) begin
        if (prev_valid) busy_after = Busy;
        prev_valid = Valid;
        if (Valid) begin
            got_q.push_back(Data);
            t_valid = $time;
        end
        if (FramingError) fe_cnt++;
`ifdef SERIAL_RX_PARITY_EN
        if (ParityError) pe_cnt++;
        if ((Valid && ParityError) || (FramingError && ParityError)) excl_bad++;
`endif
        if (Valid && FramingError) excl_bad++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at a negedge; the model decides what the frame should produce.
    task automatic send_frame(input logic [7:0] b, input int stop_len, input logic stop_val,
                              input logic par);
        logic good_par;
        Rx = 1'b0;
        t_fall = $time;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            tick(CPB);
        end
`ifdef SERIAL_RX_PARITY_EN
        Rx = par;
        tick(CPB);
        good_par = (par == ^b);
`else
        good_par = 1'b1;
`endif
        Rx = stop_val;
        tick(stop_len);
        Rx = 1'b1;
        if (!stop_val) begin
            exp_fe++;
        end else if (!good_par) begin
            exp_pe++;
        end else begin
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    initial begin
        int         n_before;
        int         lat;
        logic [7:0] b;
        logic       par;
        logic [7:0] partial;

        Reset = 1'b1;
        Rx    = 1'b1;
        tick(3);
        check("reset_data", Data, 8'h00);
        check("reset_valid", Valid, 1'b0);
        check("reset_fe", FramingError, 1'b0);
        check("reset_busy", Busy, 1'b0);
        Reset = 1'b0;
        tick(5);

        send_frame(8'hA5, CPB, 1'b1, ^8'hA5);
        tick(4);
        check("a5_count", got_q.size(), 1);
        check("a5_data", Data, 8'hA5);
        check("a5_fe", fe_cnt, 0);
        lat = int'((t_valid - t_fall) / 10);
        check("a5_latency_ok", (lat >= 153 && lat <= 155), 1'b1);
        check("a5_busy_after", busy_after, 1'b0);

        send_frame(8'h3C, CPB, 1'b0, ^8'h3C);
        tick(30);
        check("fe_count", fe_cnt, exp_fe);
        check("fe_no_valid", got_q.size(), 1);
        check("fe_data_kept", Data, 8'hA5);

        send_frame(8'h00, 10, 1'b1, ^8'h00);
        send_frame(8'hFF, CPB, 1'b1, ^8'hFF);
        tick(4);
        check("b2b_count", got_q.size(), 3);
        check("b2b_first", got_q[1], 8'h00);
        check("b2b_second", got_q[2], 8'hFF);

        n_before = got_q.size();
        Rx = 1'b0;
        tick(5);
        Rx = 1'b1;
        tick(3);
        check("glitch_busy_seen", Busy, 1'b1);
        tick(5);
        check("glitch_busy_low", Busy, 1'b0);
        check("glitch_no_valid", got_q.size(), n_before);
        check("glitch_no_fe", fe_cnt, exp_fe);

        partial = 8'h5A;
        n_before = got_q.size();
        Rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            Rx = partial[i];
            tick(CPB);
        end
        Rx = partial[4];
        tick(8);
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_data", Data, 8'h00);
        check("rst_mid_busy", Busy, 1'b0);
        exp_data = 8'h00;
        @(negedge Clock);
        Rx    = 1'b1;
        Reset = 1'b0;
        tick(200);
        check("rst_no_pulse", got_q.size(), n_before);
        check("rst_data_zero", Data, 8'h00);
        send_frame(8'h81, CPB, 1'b1, ^8'h81);
        tick(4);
        check("after_rst_data", Data, 8'h81);

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, CPB, 1'b1, 1'b1);
        tick(4);
        check("par_ok_data", Data, 8'h07);
        send_frame(8'h07, CPB, 1'b1, 1'b0);
        tick(4);
        check("par_err_count", pe_cnt, exp_pe);
        check("par_err_data_kept", Data, 8'h07);
`endif

        for (int f = 0; f < 24; f++) begin
            b   = 8'($urandom);
            par = ^b;
`ifdef SERIAL_RX_PARITY_EN
            if ($urandom_range(0, 5) == 0) par = ~par;
`endif
            if ($urandom_range(0, 7) == 0) begin
                send_frame(b, CPB, 1'b0, par);
                tick(30);
            end else begin
                send_frame(b, $urandom_range(10, 20), 1'b1, par);
                tick($urandom_range(0, 3));
            end
        end
        tick(40);

        check("final_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("byte_%0d", i), got_q[i], exp_q[i]);
        end
        check("final_data", Data, exp_data);
        check("final_fe", fe_cnt, exp_fe);
        check("final_pe", pe_cnt, exp_pe);
        check("pulse_exclusive", excl_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
